ddr_cmd_sched: RTL and testbench

DDR_CMD_SCHED -- requirements
Module: ddr_cmd_sched

---
 rtl/ddr_cmd_sched_if.sv | 36 +++
 rtl/ddr_cmd_sched.sv | 176 +++++++++++++++++
 tb/tb_ddr_cmd_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_sched_if.sv
// rtl/ddr_cmd_sched_if.sv - request and instruction-stream bundle for ddr_cmd_sched
//
// Ports carried:
//   req_valid/req_ready/req_write/req_bg/req_bank/req_row/req_col : requester side
//   M_AXIS_TDATA/M_AXIS_TVALID/M_AXIS_TREADY                       : instruction beat stream
//   state_dbg/ref_overflow                                         : status
// Modports: slave = scheduler view, master = requester/downstream view.
interface ddr_cmd_sched_if #(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [BG_WIDTH-1:0]   req_bg;
    logic [BANK_WIDTH-1:0] req_bank;
    logic [ROW_WIDTH-1:0]  req_row;
    logic [COL_WIDTH-1:0]  req_col;
    logic [127:0]          M_AXIS_TDATA;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;
    logic [1:0]            state_dbg;
    logic                  ref_overflow;

    modport slave (
        input  req_valid, req_write, req_bg, req_bank, req_row, req_col, M_AXIS_TREADY,
        output req_ready, M_AXIS_TDATA, M_AXIS_TVALID, state_dbg, ref_overflow
    );

    modport master (
        output req_valid, req_write, req_bg, req_bank, req_row, req_col, M_AXIS_TREADY,
        input  req_ready, M_AXIS_TDATA, M_AXIS_TVALID, state_dbg, ref_overflow
    );
endinterface

// File: rtl/ddr_cmd_sched.sv
// rtl/ddr_cmd_sched.sv - single-requester DDR command scheduler with open-row table and refresh
//
// Ports:
//   clk  : single clock
//   rst  : asynchronous active-high reset
//   bus  : ddr_cmd_sched_if.slave (request handshake, 128-bit instruction beat stream, status)
// Each beat carries one command in slot 0; the upper three slots are always NOP.
module ddr_cmd_sched #(
    parameter int BG_WIDTH   = 2,
    parameter int BANK_WIDTH = 2,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 17,
    parameter int T_RCD      = 4,
    parameter int T_RP       = 4,
    parameter int T_RFC      = 88,
    parameter int T_REFI     = 1950
) (
    input logic            clk,
    input logic            rst,
    ddr_cmd_sched_if.slave bus
);
    localparam int IDX_W     = BG_WIDTH + BANK_WIDTH;
    localparam int NUM_BANKS = 1 << IDX_W;
    localparam int ADDR_LSB  = 3 + BANK_WIDTH + BG_WIDTH;
    localparam int ADDR_W    = 32 - ADDR_LSB;
    localparam int T_MAX     = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                               : ((T_RCD > T_RP) ? T_RCD : T_RP);
    localparam int CNT_W     = $clog2(T_MAX);
    localparam int TMR_W     = $clog2(T_REFI);

    localparam logic [2:0] OP_PRE = 3'd1;
    localparam logic [2:0] OP_ACT = 3'd2;
    localparam logic [2:0] OP_RD  = 3'd3;
    localparam logic [2:0] OP_WR  = 3'd4;
    localparam logic [2:0] OP_REF = 3'd5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RCD = 2'd1;
    localparam logic [1:0] ST_WAIT_RP  = 2'd2;
    localparam logic [1:0] ST_WAIT_RFC = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [127:0]         tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 req_ready_q, req_ready_d;
    logic [NUM_BANKS-1:0] row_valid_q, row_valid_d;
    logic [ROW_WIDTH-1:0] open_row_q [NUM_BANKS];
    logic [ROW_WIDTH-1:0] open_row_d [NUM_BANKS];
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 ref_pending_q, ref_pending_d;
    logic                 ref_overflow_q, ref_overflow_d;

    logic [IDX_W-1:0]     req_idx;
    logic                 bank_open;
    logic                 row_hit;
    logic                 timer_wrap;

    function automatic logic [127:0] beat(input logic [2:0]            op,
                                          input logic [BG_WIDTH-1:0]   bg,
                                          input logic [BANK_WIDTH-1:0] bank,
                                          input logic [ADDR_W-1:0]     addr);
        logic [31:0] slot;
        slot = {addr, bg, bank, op};
        return {96'd0, slot};
    endfunction

    assign req_idx    = {bus.req_bg, bus.req_bank};
    assign bank_open  = row_valid_q[req_idx];
    assign row_hit    = bank_open && (open_row_q[req_idx] == bus.req_row);
    assign timer_wrap = (timer_q == TMR_W'(T_REFI - 1));

    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        tdata_d        = tdata_q;
        tvalid_d       = 1'b1;
        req_ready_d    = 1'b0;
        row_valid_d    = row_valid_q;
        open_row_d     = open_row_q;
        timer_d        = timer_wrap ? '0 : timer_q + TMR_W'(1);
        ref_pending_d  = ref_pending_q;
        ref_overflow_d = ref_overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.M_AXIS_TREADY) begin
                    tdata_d = '0;
                    if (ref_pending_q) begin
                        if (|row_valid_q) begin
                            tdata_d     = beat(OP_PRE, '0, '0, ADDR_W'(1));
                            row_valid_d = '0;
                            state_d     = ST_WAIT_RP;
                            cnt_d       = CNT_W'(T_RP - 2);
                        end else begin
                            tdata_d       = beat(OP_REF, '0, '0, '0);
                            ref_pending_d = 1'b0;
                            state_d       = ST_WAIT_RFC;
                            cnt_d         = CNT_W'(T_RFC - 2);
                        end
                    // req_ready_q high means the requester is consuming the
                    // previous acceptance this cycle; its fields are stale.
                    end else if (bus.req_valid && !req_ready_q) begin
                        if (row_hit) begin
                            tdata_d     = beat(bus.req_write ? OP_WR : OP_RD, bus.req_bg,
                                               bus.req_bank, ADDR_W'(bus.req_col));
                            req_ready_d = 1'b1;
                        end else if (!bank_open) begin
                            tdata_d              = beat(OP_ACT, bus.req_bg, bus.req_bank,
                                                        ADDR_W'(bus.req_row));
                            row_valid_d[req_idx] = 1'b1;
                            open_row_d[req_idx]  = bus.req_row;
                            state_d              = ST_WAIT_RCD;
                            cnt_d                = CNT_W'(T_RCD - 2);
                        end else begin
                            tdata_d              = beat(OP_PRE, bus.req_bg, bus.req_bank, '0);
                            row_valid_d[req_idx] = 1'b0;
                            state_d              = ST_WAIT_RP;
                            cnt_d                = CNT_W'(T_RP - 2);
                        end
                    end
                end
            end
            default: begin
                // Waits are timer-driven and finish even under backpressure;
                // only the beat register is frozen by TREADY.
                if (bus.M_AXIS_TREADY) begin
                    tdata_d = '0;
                end
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A new refresh request wins over a same-cycle clear.
        if (timer_wrap) begin
            if (ref_pending_q) begin
                ref_overflow_d = 1'b1;
            end
            ref_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            req_ready_q    <= 1'b0;
            row_valid_q    <= '0;
            open_row_q     <= '{default: '0};
            timer_q        <= '0;
            ref_pending_q  <= 1'b0;
            ref_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tdata_q        <= tdata_d;
            tvalid_q       <= tvalid_d;
            req_ready_q    <= req_ready_d;
            row_valid_q    <= row_valid_d;
            open_row_q     <= open_row_d;
            timer_q        <= timer_d;
            ref_pending_q  <= ref_pending_d;
            ref_overflow_q <= ref_overflow_d;
        end
    end

    assign bus.M_AXIS_TDATA  = tdata_q;
    assign bus.M_AXIS_TVALID = tvalid_q;
    assign bus.req_ready     = req_ready_q;
    assign bus.state_dbg     = state_q;
    assign bus.ref_overflow  = ref_overflow_q;
endmodule

// File: tb/tb_ddr_cmd_sched.sv
// tb/tb_ddr_cmd_sched.sv - scoreboard bench for ddr_cmd_sched
module tb_ddr_cmd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_cmd_sched_if bus_if ();
    ddr_cmd_sched dut (.clk(clk), .rst(rst), .bus(bus_if));

    // mode: 0 = no timing check, 1 = exact gap, 2 = minimum gap (cycles since previous command beat)
    typedef struct {
        logic [127:0] data;
        int           gap;
        int           mode;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_cmd_cyc = 0;
    int   t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input logic [127:0] d, input int gap, input int mode, input string name);
        exp_t x;
        x.data = d; x.gap = gap; x.mode = mode; x.name = name;
        exp_q.push_back(x);
    endtask

    // Monitor: every transferred command beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus_if.M_AXIS_TVALID && bus_if.M_AXIS_TREADY && bus_if.M_AXIS_TDATA != '0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %0h expected none", bus_if.M_AXIS_TDATA);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_data"}, bus_if.M_AXIS_TDATA, e.data);
                if (e.mode == 1) begin
                    check({e.name, "_gap"}, cyc - last_cmd_cyc, e.gap);
                end else if (e.mode == 2) begin
                    vectors++;
                    if (cyc - last_cmd_cyc < e.gap) begin
                        miscompares++;
                        $display("FAIL %s_mingap: got %0d expected >= %0d", e.name, cyc - last_cmd_cyc, e.gap);
                    end
                end
            end
            last_cmd_cyc = cyc;
        end
        if (!rst && bus_if.req_ready) begin
            check("ready_with_rdwr",
                  (bus_if.M_AXIS_TDATA[2:0] == 3'd3 || bus_if.M_AXIS_TDATA[2:0] == 3'd4), 1);
        end
    end

    task automatic start_req(input bit w, input logic [1:0] bg, input logic [1:0] bank,
                             input logic [16:0] row, input logic [9:0] col);
        @(posedge clk);
        #1;
        bus_if.req_write = w;
        bus_if.req_bg    = bg;
        bus_if.req_bank  = bank;
        bus_if.req_row   = row;
        bus_if.req_col   = col;
        bus_if.req_valid = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_ready(input string name, input int exp_lat);
        bit found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus_if.req_ready) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no req_ready expected latency %0d", name, exp_lat);
        end else begin
            check(name, cyc - t0, exp_lat);
        end
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit, input string name);
        bit found = 0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (bus_if.state_dbg == st) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got state %0d expected %0d", name, bus_if.state_dbg, st);
        end
    endtask

    initial begin
        bus_if.req_valid     = 1'b0;
        bus_if.req_write     = 1'b0;
        bus_if.req_bg        = '0;
        bus_if.req_bank      = '0;
        bus_if.req_row       = '0;
        bus_if.req_col       = '0;
        bus_if.M_AXIS_TREADY = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", bus_if.M_AXIS_TVALID, 0);
        check("rst_tdata", bus_if.M_AXIS_TDATA, 0);
        check("rst_ready", bus_if.req_ready, 0);
        check("rst_state", bus_if.state_dbg, 0);
        check("rst_ovf", bus_if.ref_overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_tvalid", bus_if.M_AXIS_TVALID, 1);
        check("first_nop", bus_if.M_AXIS_TDATA, 0);

        // Closed bank: ACT bg1 bank2 row 0x155, RD col 0x20 four cycles later
        push(128'h0000AAB2, 0, 0, "t1_act");
        push(128'h00001033, 4, 1, "t1_rd");
        start_req(0, 2'd1, 2'd2, 17'h155, 10'h20);
        wait_ready("t1_lat", 5);

        // Row hit WR
        push(128'h000010B4, 0, 0, "t2_wr");
        start_req(1, 2'd1, 2'd2, 17'h155, 10'h21);
        wait_ready("t2_hit_lat", 1);

        // Row conflict: PRE bank, ACT row 0x156, RD col 0x40
        push(128'h00000031, 0, 0, "t2_pre");
        push(128'h0000AB32, 4, 1, "t2_act");
        push(128'h00002033, 4, 1, "t2_rd");
        start_req(0, 2'd1, 2'd2, 17'h156, 10'h40);
        wait_ready("t2_conf_lat", 9);

        // Backpressure during WAIT_RCD
        push(128'h0000018A, 0, 0, "t3_act");
        push(128'h0000028B, 1, 1, "t3_rd");
        start_req(0, 2'd0, 2'd1, 17'h3, 10'h5);
        @(posedge clk);
        #1 bus_if.M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) check("t3_state_rcd", bus_if.state_dbg, 1);
            check("t3_hold", bus_if.M_AXIS_TDATA, 128'h0000018A);
        end
        @(posedge clk);
        #1 bus_if.M_AXIS_TREADY = 1'b1;
        wait_ready("t3_lat", 12);

        // Refresh with open rows: PRE all, REF, then the pending request re-activates
        push(128'h00000081, 0, 0, "t4_pre_all");
        push(128'h00000005, 4, 1, "t4_ref");
        push(128'h0000018A, 88, 2, "t4_act");
        push(128'h0000030B, 4, 1, "t4_rd");
        wait_state(2'd2, 2500, "t4_wait_rp");
        start_req(0, 2'd0, 2'd1, 17'h3, 10'h6);
        wait_ready("t4_lat", 95);

        // Long stall forces a missed refresh
        @(posedge clk);
        #1 bus_if.M_AXIS_TREADY = 1'b0;
        repeat (2 * 1950 + 20) @(posedge clk);
        @(negedge clk);
        check("t5_ovf_set", bus_if.ref_overflow, 1);
        push(128'h00000081, 0, 0, "t5_pre_all");
        push(128'h00000005, 4, 1, "t5_ref");
        @(posedge clk);
        #1 bus_if.M_AXIS_TREADY = 1'b1;
        wait_state(2'd3, 50, "t5_wait_rfc");
        check("t5_ovf_sticky", bus_if.ref_overflow, 1);

        // Reset mid-WAIT_RFC
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_queue_drained", exp_q.size(), 0);
        check("rst2_tvalid", bus_if.M_AXIS_TVALID, 0);
        check("rst2_tdata", bus_if.M_AXIS_TDATA, 0);
        check("rst2_state", bus_if.state_dbg, 0);
        check("rst2_ovf", bus_if.ref_overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_tvalid_after", bus_if.M_AXIS_TVALID, 1);
        check("rst2_nop", bus_if.M_AXIS_TDATA, 0);

        // After reset every bank is closed
        push(128'h0000018A, 0, 0, "t6_act");
        push(128'h0000038B, 4, 1, "t6_rd");
        start_req(0, 2'd0, 2'd1, 17'h3, 10'h7);
        wait_ready("t6_lat", 5);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
